conv55_window_gen: RTL and testbench

//  Producer side of the 5x5 conv array interface. Takes a raster pixel stream and builds

---
 rtl/conv55_window_gen_pkg.sv | 18 +
 rtl/conv55_window_gen_if.sv | 49 ++++
 rtl/conv55_window_gen_line_buf.sv | 31 +++
 rtl/conv55_window_gen.sv | 148 ++++++++++++++
 tb/tb_conv55_window_gen.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv55_window_gen_pkg.sv
// Shared definitions for the 5x5 window generator.
//   K      : kernel / window edge length
//   KK     : number of taps in a window (row-major)
//   ACC_W  : accumulator width of the conv55 consumer downstream
//   state_t: frame-level FSM state, also exported on the debug port
package conv55_window_gen_pkg;

  localparam int K     = 5;
  localparam int KK    = K * K;
  localparam int ACC_W = 18;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

endpackage

// File: rtl/conv55_window_gen_if.sv
// Bundle between a pixel/kernel source, the window generator and the conv55
// consumer.
//   pix_*   : raster pixel stream into the generator
//   kern_*  : kernel weight write port and the 25 stored weights
//   win_*   : window stream out of the generator
//   frame_done : one-cycle pulse after the last window of a frame is taken
//
// Handshake (both pix_* and win_* channels): a transfer happens on a rising
// clock edge where valid and ready are both 1. While valid is 1 and ready is 0
// the producer keeps valid and its payload unchanged. Ready may depend
// combinationally on the other side's valid; valid never depends on ready.
interface conv55_window_gen_if #(
  parameter int DATA_W = 8
);
  import conv55_window_gen_pkg::*;

  logic                 pix_valid;
  logic                 pix_ready;
  logic                 pix_sof;
  logic [DATA_W-1:0]    pix_data;

  logic                 kern_wr_en;
  logic [4:0]           kern_wr_addr;
  logic [DATA_W-1:0]    kern_wr_data;

  logic                 win_valid;
  logic                 win_ready;
  logic [KK*DATA_W-1:0] win_data;
  logic [KK*DATA_W-1:0] kern_data;
  logic                 win_last;
  logic                 frame_done;

  // Source side: drives pixels, weights and the window ready.
  modport master (
    output pix_valid, pix_sof, pix_data,
    output kern_wr_en, kern_wr_addr, kern_wr_data,
    output win_ready,
    input  pix_ready, win_valid, win_data, kern_data, win_last, frame_done
  );

  // Generator side.
  modport slave (
    input  pix_valid, pix_sof, pix_data,
    input  kern_wr_en, kern_wr_addr, kern_wr_data,
    input  win_ready,
    output pix_ready, win_valid, win_data, kern_data, win_last, frame_done
  );

endinterface

// File: rtl/conv55_window_gen_line_buf.sv
// One image row of delay: dout is the sample written DEPTH advances ago.
//   clk  : rising-edge clock
//   adv  : shift enable, one per accepted frame pixel
//   din  : sample entering the line
//   dout : sample leaving the line (same column, previous row)
// Contents are not reset; stale data is never used because windows are only
// emitted once four full rows of the current frame have been pushed through.
module conv55_window_gen_line_buf #(
  parameter int DEPTH  = 32,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              adv,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] taps [DEPTH];

  always_ff @(posedge clk) begin
    if (adv) begin
      taps[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        taps[i] <= taps[i-1];
      end
    end
  end

  assign dout = taps[DEPTH-1];

endmodule

// File: rtl/conv55_window_gen.sv
// 5x5 sliding-window generator (stride 1, no padding) feeding a conv55 array.
// Four chained line buffers deliver the column above each incoming pixel; a
// 5x5 shift array holds the current window. Also stores the 25 kernel weights.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : slave side of conv55_window_gen_if (pixels, weights, windows)
//   dbg_state  : current FSM state
module conv55_window_gen
  import conv55_window_gen_pkg::*;
#(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int DATA_W = 8
) (
  input  logic   clk,
  input  logic   rst_n,
  conv55_window_gen_if.slave bus,
  output state_t dbg_state
);

  localparam int CW  = $clog2(IMG_W);
  localparam int RW  = $clog2(IMG_H);
  localparam int NLB = K - 1;

  state_t            state_q, state_d;
  logic [CW-1:0]     col_q, cur_col;
  logic [RW-1:0]     row_q, cur_row;
  logic              win_valid_q, win_last_q, frame_done_q;
  logic [DATA_W-1:0] win_q  [KK];
  logic [DATA_W-1:0] kern_q [KK];
  logic [DATA_W-1:0] lb_out [NLB];
  logic [DATA_W-1:0] col_in [K];
  logic              pix_ready, pix_acc, frame_acc, win_take, emit, last_pix;

  always_comb begin
    pix_ready = 1'b0;
    case (state_q)
      IDLE:    pix_ready = 1'b1;
      // Single output register: a new pixel may enter only if the window
      // it could produce has somewhere to go this cycle.
      STREAM:  pix_ready = !win_valid_q || bus.win_ready;
      DRAIN:   pix_ready = 1'b0;
      default: pix_ready = 1'b0;
    endcase

    pix_acc   = bus.pix_valid && pix_ready;
    // In IDLE only a start-of-frame pixel joins a frame; others are dropped.
    frame_acc = pix_acc && ((state_q != IDLE) || bus.pix_sof);
    win_take  = win_valid_q && bus.win_ready;

    // A start-of-frame pixel is always (0,0), whatever the counters say.
    cur_col   = bus.pix_sof ? '0 : col_q;
    cur_row   = bus.pix_sof ? '0 : row_q;
    emit      = frame_acc && (cur_row >= RW'(K-1)) && (cur_col >= CW'(K-1));
    last_pix  = (cur_row == RW'(IMG_H-1)) && (cur_col == CW'(IMG_W-1));

    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_acc) state_d = STREAM;
      STREAM:  if (frame_acc && last_pix) state_d = DRAIN;
      // The only window possible in DRAIN is the frame's last one.
      DRAIN:   if (win_take) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  for (genvar g = 0; g < NLB; g++) begin : g_lb
    logic [DATA_W-1:0] lb_in;
    if (g == 0) begin : g_head
      assign lb_in = bus.pix_data;
    end else begin : g_tail
      assign lb_in = lb_out[g-1];
    end
    conv55_window_gen_line_buf #(
      .DEPTH  (IMG_W),
      .DATA_W (DATA_W)
    ) u_lb (
      .clk  (clk),
      .adv  (frame_acc),
      .din  (lb_in),
      .dout (lb_out[g])
    );
  end

  // Column entering the window: top row is the oldest line buffer output.
  assign col_in[K-1] = bus.pix_data;
  for (genvar r = 0; r < NLB; r++) begin : g_col
    assign col_in[r] = lb_out[NLB-1-r];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      win_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < KK; i++) begin
        win_q[i]  <= '0;
        kern_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      frame_done_q <= (state_q == DRAIN) && win_take;

      if (frame_acc) begin
        if (cur_col == CW'(IMG_W-1)) begin
          col_q <= '0;
          row_q <= (cur_row == RW'(IMG_H-1)) ? '0 : cur_row + 1'b1;
        end else begin
          col_q <= cur_col + 1'b1;
          row_q <= cur_row;
        end
        // Any previous window is being taken this cycle (see pix_ready), so
        // the output register is simply reloaded.
        win_valid_q <= emit;
        win_last_q  <= emit && last_pix;
        for (int r = 0; r < K; r++) begin
          for (int c = 0; c < K-1; c++) begin
            win_q[r*K+c] <= win_q[r*K+c+1];
          end
          win_q[r*K+K-1] <= col_in[r];
        end
      end else if (win_take) begin
        win_valid_q <= 1'b0;
        win_last_q  <= 1'b0;
      end

      if ((state_q == IDLE) && bus.kern_wr_en) begin
        for (int i = 0; i < KK; i++) begin
          if (bus.kern_wr_addr == 5'(i)) kern_q[i] <= bus.kern_wr_data;
        end
      end
    end
  end

  for (genvar i = 0; i < KK; i++) begin : g_pack
    assign bus.win_data[i*DATA_W +: DATA_W]  = win_q[i];
    assign bus.kern_data[i*DATA_W +: DATA_W] = kern_q[i];
  end

  assign bus.pix_ready  = pix_ready;
  assign bus.win_valid  = win_valid_q;
  assign bus.win_last   = win_last_q;
  assign bus.frame_done = frame_done_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_conv55_window_gen.sv
module tb_conv55_window_gen;
  import conv55_window_gen_pkg::*;

  localparam int IMG_W = 32;
  localparam int IMG_H = 32;
  localparam int DW    = 8;
  localparam int WW    = KK * DW;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  state_t dbg_state;
  always #5 clk = ~clk;

  conv55_window_gen_if #(.DATA_W(DW)) bus ();

  conv55_window_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .DATA_W (DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [WW-1:0] exp_q[$];
  logic          exp_last_q[$];
  logic [WW-1:0] exp_kern = '0;
  logic [WW-1:0] cap_first = '0;
  logic [WW-1:0] cap_wrap = '0;
  logic [WW-1:0] bp_ref = '0;
  logic [DW-1:0] img [IMG_H][IMG_W];
  int checks = 0;
  int errors = 0;
  int win_idx = 0;
  int fd_count = 0;
  int bp_cnt = 0;
  int ready_mode = 0;
  int exp_total = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic fill_img(input bit ramp);
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        img[r][c] = ramp ? DW'(r * IMG_W + c) : DW'($urandom_range(0, 255));
  endtask

  // Every window whose bottom-right pixel lies among the first n_pix pixels.
  task automatic push_expected(input int n_pix);
    logic [WW-1:0] w;
    for (int r = K-1; r < IMG_H; r++)
      for (int c = K-1; c < IMG_W; c++)
        if (r * IMG_W + c < n_pix) begin
          for (int i = 0; i < KK; i++)
            w[i*DW +: DW] = img[r-(K-1)+i/K][c-(K-1)+i%K];
          exp_q.push_back(w);
          exp_last_q.push_back(r == IMG_H-1 && c == IMG_W-1);
          exp_total++;
        end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_pixel(input logic [DW-1:0] d, input logic sof);
    int n;
    n = 0;
    bus.pix_valid = 1'b1;
    bus.pix_data  = d;
    bus.pix_sof   = sof;
    forever begin
      @(negedge clk);
      if (bus.pix_ready) break;
      n++;
      if (n > 1000) break;
    end
    if (n > 1000) chk("pix_accept_timeout", 256'(bus.pix_ready), 256'(1));
    @(posedge clk); #1;
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
  endtask

  task automatic stream_frame(input int n_pix, input int kern_poke_at);
    for (int p = 0; p < n_pix; p++) begin
      if (p == kern_poke_at) begin
        bus.kern_wr_en   = 1'b1;
        bus.kern_wr_addr = 5'd3;
        bus.kern_wr_data = 8'hAA;
      end
      send_pixel(img[p / IMG_W][p % IMG_W], p == 0);
      bus.kern_wr_en = 1'b0;
    end
  endtask

  task automatic write_kern(input logic [4:0] addr, input logic [DW-1:0] data);
    bus.kern_wr_en   = 1'b1;
    bus.kern_wr_addr = addr;
    bus.kern_wr_data = data;
    @(posedge clk); #1;
    bus.kern_wr_en = 1'b0;
  endtask

  task automatic load_kernel();
    for (int i = 0; i < KK; i++) begin
      write_kern(5'(i), DW'(i + 1));
      exp_kern[i*DW +: DW] = DW'(i + 1);
    end
  endtask

  task automatic wait_frame_done(input int target);
    int n;
    n = 0;
    while (fd_count < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    chk("frame_done_count", 256'(fd_count), 256'(target));
  endtask

  // ---------------- window ready generator ----------------
  initial begin
    bus.win_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        1:       bus.win_ready = ($urandom_range(0, 3) != 0);
        2:       bus.win_ready = (bp_cnt >= 10) ? ($urandom_range(0, 3) != 0) : 1'b0;
        default: bus.win_ready = 1'b1;
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.frame_done) fd_count++;
      if (ready_mode == 2 && bp_cnt < 10 && bus.win_valid && !bus.win_ready) begin
        if (bp_cnt == 0) bp_ref = bus.win_data;
        else chk("bp_win_data_stable", 256'(bus.win_data), 256'(bp_ref));
        chk("bp_pix_ready", 256'(bus.pix_ready), 256'(0));
        bp_cnt++;
      end
      if (bus.win_valid && bus.win_ready) begin
        chk("spurious_window", 256'(exp_q.size() > 0), 256'(1));
        if (exp_q.size() > 0) begin
          chk("win_data", 256'(bus.win_data), 256'(exp_q.pop_front()));
          chk("win_last", 256'(bus.win_last), 256'(exp_last_q.pop_front()));
          chk("kern_data", 256'(bus.kern_data), 256'(exp_kern));
        end
        if (win_idx == 0) cap_first = bus.win_data;
        if (win_idx == IMG_W - (K-1)) cap_wrap = bus.win_data;
        win_idx++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // ---------------- directed sequence ----------------
  initial begin
    bus.pix_valid    = 1'b0;
    bus.pix_sof      = 1'b0;
    bus.pix_data     = '0;
    bus.kern_wr_en   = 1'b0;
    bus.kern_wr_addr = '0;
    bus.kern_wr_data = '0;

    // Power-on reset.
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_win_valid", 256'(bus.win_valid), 256'(0));
    chk("rst_win_last", 256'(bus.win_last), 256'(0));
    chk("rst_frame_done", 256'(bus.frame_done), 256'(0));
    chk("rst_win_data", 256'(bus.win_data), 256'(0));
    chk("rst_kern_data", 256'(bus.kern_data), 256'(0));
    chk("rst_pix_ready", 256'(bus.pix_ready), 256'(1));
    chk("rst_state", 256'(dbg_state), 256'(IDLE));

    // Kernel load; out-of-range addresses must not disturb anything.
    load_kernel();
    @(negedge clk);
    chk("kern_load", 256'(bus.kern_data), 256'(exp_kern));
    write_kern(5'd25, 8'hEE);
    write_kern(5'd31, 8'hEE);
    @(negedge clk);
    chk("kern_addr_gt24", 256'(bus.kern_data), 256'(exp_kern));

    // Reset in the middle of a frame.
    fill_img(1'b0);
    push_expected(300);
    stream_frame(300, -1);
    repeat (4) @(negedge clk);
    chk("partial_drained", 256'(exp_q.size()), 256'(0));
    chk("mid_state_stream", 256'(dbg_state), 256'(STREAM));
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_kern = '0;
    @(negedge clk);
    chk("midrst_win_valid", 256'(bus.win_valid), 256'(0));
    chk("midrst_win_data", 256'(bus.win_data), 256'(0));
    chk("midrst_kern_data", 256'(bus.kern_data), 256'(0));
    chk("midrst_pix_ready", 256'(bus.pix_ready), 256'(1));
    chk("midrst_state", 256'(dbg_state), 256'(IDLE));
    repeat (5) @(negedge clk);
    chk("midrst_no_frame_done", 256'(fd_count), 256'(0));

    // Full ramp frame, always ready, junk pixels before start of frame,
    // kernel write attempted mid-frame.
    load_kernel();
    fill_img(1'b1);
    win_idx = 0; exp_total = 0; fd_count = 0;
    for (int j = 0; j < 3; j++) send_pixel(8'hEE, 1'b0);
    push_expected(IMG_W * IMG_H);
    stream_frame(IMG_W * IMG_H, 100);
    // Next frame's start offered while draining must be refused.
    bus.pix_valid = 1'b1;
    bus.pix_sof   = 1'b1;
    bus.pix_data  = 8'h55;
    @(negedge clk);
    chk("drain_pix_ready", 256'(bus.pix_ready), 256'(0));
    chk("drain_state", 256'(dbg_state), 256'(DRAIN));
    chk("drain_win_last", 256'(bus.win_last), 256'(1));
    @(posedge clk); #1;
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
    wait_frame_done(1);
    chk("ramp_win_count", 256'(win_idx), 256'(784));
    chk("ramp_queue_empty", 256'(exp_q.size()), 256'(0));
    chk("ramp_first_b0", 256'(cap_first[7:0]), 256'(8'h00));
    chk("ramp_first_b24", 256'(cap_first[24*DW +: DW]), 256'(8'd132));
    chk("ramp_wrap_b0", 256'(cap_wrap[7:0]), 256'(8'd32));
    chk("ramp_wrap_b24", 256'(cap_wrap[24*DW +: DW]), 256'(8'd164));
    chk("kern_stream_write_ignored", 256'(bus.kern_data[3*DW +: DW]), 256'(8'd4));
    chk("post_frame_state", 256'(dbg_state), 256'(IDLE));

    // Backpressure: hold ready low for the first window, then random ready.
    fill_img(1'b0);
    win_idx = 0; exp_total = 0; fd_count = 0; bp_cnt = 0;
    ready_mode = 2;
    push_expected(IMG_W * IMG_H);
    stream_frame(IMG_W * IMG_H, -1);
    wait_frame_done(1);
    chk("bp_hold_cycles", 256'(bp_cnt), 256'(10));
    chk("bp_win_count", 256'(win_idx), 256'(784));
    chk("bp_queue_empty", 256'(exp_q.size()), 256'(0));

    // Abort: restart with start of frame at pixel 500.
    ready_mode = 1;
    win_idx = 0; exp_total = 0; fd_count = 0;
    fill_img(1'b0);
    push_expected(500);
    stream_frame(500, -1);
    fill_img(1'b0);
    push_expected(IMG_W * IMG_H);
    stream_frame(IMG_W * IMG_H, -1);
    wait_frame_done(1);
    chk("abort_win_count", 256'(win_idx), 256'(exp_total));
    chk("abort_queue_empty", 256'(exp_q.size()), 256'(0));

    // Kernel write in IDLE takes effect.
    ready_mode = 0;
    write_kern(5'd3, 8'hAA);
    exp_kern[3*DW +: DW] = 8'hAA;
    @(negedge clk);
    chk("kern_idle_write_b3", 256'(bus.kern_data[3*DW +: DW]), 256'(8'hAA));
    chk("kern_idle_write_all", 256'(bus.kern_data), 256'(exp_kern));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
